// File: rtl/usr_sequencer_if.sv
// ---------------------------------------------------------------------------
// usr_sequencer_if
// Bundles the command handshake, the shift-register control/feedback lines
// and the completion status of usr_sequencer.
//   master : requester side (drives the command, supplies register Q)
//   slave  : sequencer side (drives register controls and status)
// Signals:
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/data/count/serial    command fields
//   sr_q                        Q fed back from the shift register
//   sr_s1/sr_s0/sr_msb_in/sr_lsb_in/sr_i   register control
//   busy/done/result/err        status
// ---------------------------------------------------------------------------
interface usr_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_serial;
    logic [WIDTH-1:0] sr_q;
    logic             sr_s1;
    logic             sr_s0;
    logic             sr_msb_in;
    logic             sr_lsb_in;
    logic [WIDTH-1:0] sr_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_serial, sr_q,
        input  cmd_ready, sr_s1, sr_s0, sr_msb_in, sr_lsb_in, sr_i,
               busy, done, result, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_serial, sr_q,
        output cmd_ready, sr_s1, sr_s0, sr_msb_in, sr_lsb_in, sr_i,
               busy, done, result, err
    );
endinterface

// File: rtl/usr_sequencer.sv
// ---------------------------------------------------------------------------
// usr_sequencer
// Command sequencer for a universal shift register. Accepts one command per
// valid/ready handshake (load, shift right N, shift left N, optional rotate
// right N), drives the register mode/serial/parallel inputs cycle by cycle,
// and returns the final Q in result with a one-cycle done pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : usr_sequencer_if.slave (command, register control, status)
// Build option:
//   USR_SEQ_ROTATE_EN  when defined, op 11 rotates right (MSB_in = Q[0]);
//                      otherwise op 11 is illegal and completes with err.
// ---------------------------------------------------------------------------
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    usr_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_serial;
    logic             r_illegal;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_err;

    logic             w_illegal_op;
    logic             w_accept;

    logic             w_ready;
    logic             w_busy;
    logic             w_s1;
    logic             w_s0;
    logic             w_msb_in;
    logic             w_lsb_in;
    logic [WIDTH-1:0] w_sr_i;

`ifdef USR_SEQ_ROTATE_EN
    assign w_illegal_op = 1'b0;
`else
    assign w_illegal_op = (bus.cmd_op == OP_ROR);
`endif

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_LOAD)
                        w_state_next = S_LOAD;
                    else if (w_illegal_op || (bus.cmd_count == '0))
                        w_state_next = S_DONE;
                    else
                        w_state_next = S_SHIFT;
                end
            end
            S_LOAD:  w_state_next = S_DONE;
            // Counter holds the remaining steps including the current one.
            S_SHIFT: if (r_count == CNT_W'(1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: register controls derive from state and latched command only
    always_comb begin
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        w_s1     = 1'b0;
        w_s0     = 1'b0;
        w_msb_in = 1'b0;
        w_lsb_in = 1'b0;
        w_sr_i   = '0;
        case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_LOAD: begin
                w_busy = 1'b1;
                w_s1   = 1'b1;
                w_s0   = 1'b1;
                w_sr_i = r_data;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                case (r_op)
                    OP_SHR: begin
                        w_s0     = 1'b1;
                        w_msb_in = r_serial;
                    end
                    OP_SHL: begin
                        w_s1     = 1'b1;
                        w_lsb_in = r_serial;
                    end
`ifdef USR_SEQ_ROTATE_EN
                    OP_ROR: begin
                        // Feed the outgoing LSB back into the MSB each step.
                        w_s0     = 1'b1;
                        w_msb_in = bus.sr_q[0];
                    end
`endif
                    default: ;
                endcase
            end
            S_DONE:  w_busy = 1'b1;
            default: ;
        endcase
    end

    // Command latch, step counter and registered completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_data    <= '0;
            r_count   <= '0;
            r_serial  <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_op      <= bus.cmd_op;
                r_data    <= bus.cmd_data;
                r_count   <= bus.cmd_count;
                r_serial  <= bus.cmd_serial;
                r_illegal <= w_illegal_op;
            end
            if (r_state == S_SHIFT)
                r_count <= r_count - CNT_W'(1);
            // Q is stable during DONE (mode hold), so capture it here.
            if (r_state == S_DONE) begin
                r_result <= bus.sr_q;
                r_done   <= 1'b1;
                r_err    <= r_illegal;
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.sr_s1     = w_s1;
    assign bus.sr_s0     = w_s0;
    assign bus.sr_msb_in = w_msb_in;
    assign bus.sr_lsb_in = w_lsb_in;
    assign bus.sr_i      = w_sr_i;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.result    = r_result;

endmodule

// File: tb/tb_usr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usr_sequencer
// Drives usr_sequencer together with a behavioural 4-bit universal shift
// register. Commands come from a vector table; each command's expected
// outcome is pushed to a scoreboard queue when driven and popped when done
// is seen. Latency is counted in clock edges from the edge after which the
// command is presented. Commands are issued back to back: each new command
// is presented in the cycle where the previous done is high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usr_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usr_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural universal shift register (environment)
    logic [WIDTH-1:0] q_reg;
    always @(posedge clk) begin
        if (rst)
            q_reg <= '0;
        else begin
            case ({bus.sr_s1, bus.sr_s0})
                2'b01:   q_reg <= {bus.sr_msb_in, q_reg[WIDTH-1:1]};
                2'b10:   q_reg <= {q_reg[WIDTH-2:0], bus.sr_lsb_in};
                2'b11:   q_reg <= bus.sr_i;
                default: q_reg <= q_reg;
            endcase
        end
    end
    assign bus.sr_q = q_reg;

`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] count;
        logic       serial;
        logic [3:0] exp_result;
        logic       exp_err;
        int         exp_lat;
        int         exp_active;
        logic [1:0] exp_mode;
    } vec_t;

    typedef struct {
        logic [3:0] result;
        logic       err;
        int         lat;
        int         active;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input string nm, input logic [1:0] op,
                           input logic [3:0] data, input logic [2:0] count, input logic serial,
                           input logic [3:0] res, input logic e, input int lat,
                           input int act, input logic [1:0] mode);
        vecs[idx].name       = nm;
        vecs[idx].op         = op;
        vecs[idx].data       = data;
        vecs[idx].count      = count;
        vecs[idx].serial     = serial;
        vecs[idx].exp_result = res;
        vecs[idx].exp_err    = e;
        vecs[idx].exp_lat    = lat;
        vecs[idx].exp_active = act;
        vecs[idx].exp_mode   = mode;
    endtask

    // Must be entered just after a falling edge.
    task automatic run_cmd(input vec_t v);
        int   edges;
        int   active;
        int   bad;
        bit   seen;
        logic [1:0] mode;
        logic exp_msb;
        logic exp_lsb;
        logic [3:0] exp_i;
        exp_t e;
        exp_t got;

        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = v.op;
        bus.cmd_data   = v.data;
        bus.cmd_count  = v.count;
        bus.cmd_serial = v.serial;
        sb_q.push_back('{v.exp_result, v.exp_err, v.exp_lat, v.exp_active});

        edges = 0; active = 0; bad = 0; seen = 1'b0;
        got = '{4'h0, 1'b0, 0, 0};
        while (!seen && edges < TIMEOUT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                // Scramble the command inputs: the command must already be latched.
                bus.cmd_valid  = 1'b0;
                bus.cmd_data   = ~v.data;
                bus.cmd_serial = ~v.serial;
                bus.cmd_count  = ~v.count;
                check({v.name, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
                check({v.name, ".ready_after_accept"}, 32'(bus.cmd_ready), 32'd0);
                check({v.name, ".done_one_cycle"}, 32'(bus.done), 32'd0);
                check({v.name, ".err_one_cycle"}, 32'(bus.err), 32'd0);
            end
            mode = {bus.sr_s1, bus.sr_s0};
            exp_msb = 1'b0;
            exp_lsb = 1'b0;
            exp_i   = 4'h0;
            if (mode == 2'b01) exp_msb = (ROT && v.op == 2'b11) ? q_reg[0] : v.serial;
            if (mode == 2'b10) exp_lsb = v.serial;
            if (mode == 2'b11) exp_i   = v.data;
            if (mode != 2'b00) begin
                active++;
                if (mode != v.exp_mode) bad++;
            end
            if (bus.sr_msb_in !== exp_msb || bus.sr_lsb_in !== exp_lsb || bus.sr_i !== exp_i)
                bad++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                got.result = bus.result;
                got.err    = bus.err;
                got.lat    = edges;
                got.active = active;
                check({v.name, ".ready_with_done"}, 32'(bus.cmd_ready), 32'd1);
                check({v.name, ".busy_with_done"}, 32'(bus.busy), 32'd0);
            end
        end

        e = sb_q.pop_front();
        check({v.name, ".done_seen"}, 32'(seen), 32'd1);
        check({v.name, ".result"}, 32'(got.result), 32'(e.result));
        check({v.name, ".err"}, 32'(got.err), 32'(e.err));
        check({v.name, ".latency"}, 32'(got.lat), 32'(e.lat));
        check({v.name, ".mode_cycles"}, 32'(got.active), 32'(e.active));
        check({v.name, ".ctrl_lines_bad"}, 32'(bad), 32'd0);
        $display("txn %-8s op=%b data=%b cnt=%0d ser=%b -> result=%b err=%b lat=%0d modecyc=%0d",
                 v.name, v.op, v.data, v.count, v.serial, got.result, got.err, got.lat, got.active);
    endtask

    initial begin
        vec_t v;

        // Table: starting from Q=0000 after reset.
        set_vec(0, "load1101", 2'b00, 4'b1101, 3'd0, 1'b0, 4'b1101, 1'b0, 3, 1, 2'b11);
        set_vec(1, "shr2s0",   2'b01, 4'b0000, 3'd2, 1'b0, 4'b0011, 1'b0, 4, 2, 2'b01);
        set_vec(2, "shl1s1",   2'b10, 4'b0000, 3'd1, 1'b1, 4'b0111, 1'b0, 3, 1, 2'b10);
        set_vec(3, "shr0",     2'b01, 4'b0000, 3'd0, 1'b1, 4'b0111, 1'b0, 2, 0, 2'b01);
        set_vec(4, "reload",   2'b00, 4'b1101, 3'd3, 1'b1, 4'b1101, 1'b0, 3, 1, 2'b11);
        if (ROT) begin
            set_vec(5, "ror1",   2'b11, 4'b0000, 3'd1, 1'b0, 4'b1110, 1'b0, 3, 1, 2'b01);
            set_vec(6, "shl3s1", 2'b10, 4'b0000, 3'd3, 1'b1, 4'b0111, 1'b0, 5, 3, 2'b10);
        end else begin
            set_vec(5, "ror1",   2'b11, 4'b0000, 3'd1, 1'b0, 4'b1101, 1'b1, 2, 0, 2'b01);
            set_vec(6, "shl3s1", 2'b10, 4'b0000, 3'd3, 1'b1, 4'b1111, 1'b0, 5, 3, 2'b10);
        end
        set_vec(7, "shr7s1",   2'b01, 4'b0000, 3'd7, 1'b1, 4'b1111, 1'b0, 9, 7, 2'b01);
        set_vec(8, "shr3s0",   2'b01, 4'b0000, 3'd3, 1'b0, 4'b0001, 1'b0, 5, 3, 2'b01);
        if (ROT)
            set_vec(9, "ror2s1", 2'b11, 4'b0000, 3'd2, 1'b1, 4'b0100, 1'b0, 4, 2, 2'b01);
        else
            set_vec(9, "ror2s1", 2'b11, 4'b0000, 3'd2, 1'b1, 4'b0001, 1'b1, 2, 0, 2'b01);

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_data   = 4'h0;
        bus.cmd_count  = 3'd0;
        bus.cmd_serial = 1'b0;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.mode", 32'({bus.sr_s1, bus.sr_s0}), 32'd0);

        @(negedge clk);
        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Reset in the middle of a 5-step shift right, after two steps.
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'b01;
        bus.cmd_count  = 3'd5;
        bus.cmd_serial = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midshift.mode_before_rst", 32'({bus.sr_s1, bus.sr_s0}), 32'd1);
        rst = 1'b1;
        #1;
        check("midshift.mode", 32'({bus.sr_s1, bus.sr_s0}), 32'd0);
        check("midshift.msb_in", 32'(bus.sr_msb_in), 32'd0);
        check("midshift.busy", 32'(bus.busy), 32'd0);
        check("midshift.done", 32'(bus.done), 32'd0);
        check("midshift.result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midshift.ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        $display("txn rstmid   op=01 cnt=5 reset after 2 steps -> outputs cleared");

        v.name = "load1010"; v.op = 2'b00; v.data = 4'b1010; v.count = 3'd0; v.serial = 1'b0;
        v.exp_result = 4'b1010; v.exp_err = 1'b0; v.exp_lat = 3; v.exp_active = 1; v.exp_mode = 2'b11;
        run_cmd(v);

        @(negedge clk);
        check("final.done_cleared", 32'(bus.done), 32'd0);
        check("final.result_held", 32'(bus.result), 32'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
